// File: rtl/fetch_unit.sv
// Purpose: PC + instruction register feeding decode; drives async-read instruction memory. Optional: FETCH_ZERO_HALT_EN.
// Latency: address presented in cycle N, instruction valid at the output after edge N (1 cycle).
// Backpressure: if_valid/if_ready handshake; output holds while valid and not accepted; redirect squashes and overrides.
module fetch_unit #(
  parameter int                ADDR_W   = 6,
  parameter int                INSTR_W  = 17,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ir_enable,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              load;
  logic              halt_blk;

`ifdef FETCH_ZERO_HALT_EN
  logic halted_q;

  // Halt latch: set when an all-zero word is loaded, cleared only by redirect or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (load && (imem_instr == '0)) begin
      halted_q <= 1'b1;
    end
  end

  assign halt_blk = halted_q;
  assign halted   = halted_q;
`else
  assign halt_blk = 1'b0;
  assign halted   = 1'b0;
`endif

  // Load whenever the output slot is free or being drained, unless redirected or halted.
  always_comb begin
    pc_inc    = pc + ONE;
    load      = !redirect_valid && (!if_valid || if_ready) && !halt_blk;
    ir_enable = load && rst_n;
  end

  assign imem_addr = pc;

  // PC and instruction register; redirect has priority, a stall simply holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
    end else if (redirect_valid) begin
      // Current word's handshake (if any) completes this edge; later fetches are squashed.
      pc       <= redirect_pc;
      if_valid <= 1'b0;
    end else if (load) begin
      if_instr    <= imem_instr;
      if_pc       <= pc;
      if_pc_plus1 <= pc_inc;
      pc          <= pc_inc;
      if_valid    <= 1'b1;
    end else if (if_valid && if_ready) begin
      // Only reachable while halted: the last (zero) word drains and the slot empties.
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [16:0] imem_instr;
  logic        ir_enable;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [16:0] if_instr;
  logic [5:0]  if_pc;
  logic [5:0]  if_pc_plus1;
  logic        halted;

  logic [16:0] mem [0:63];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_unit #(.ADDR_W(6), .INSTR_W(17), .RESET_PC(6'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ir_enable      (ir_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [5:0] pc,
                           input logic [16:0] instr);
    check({tag, ".valid"}, 32'(if_valid), 32'(v));
    if (v) begin
      check({tag, ".pc"},    32'(if_pc),    32'(pc));
      check({tag, ".instr"}, 32'(if_instr), 32'(instr));
    end
  endtask

  task automatic do_redirect(input logic [5:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #0;
    check("redir.ir_en", 32'(ir_enable), 32'd0);
    tick();
    check("redir.valid", 32'(if_valid), 32'd0);
    check("redir.addr",  32'(imem_addr), 32'(tgt));
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 17'h10000 + 17'(i);
    mem[0]  = 17'h00001;
    mem[1]  = 17'h0C217;
    mem[2]  = 17'h06587;
    mem[3]  = 17'h0B000;
    mem[5]  = 17'h0AAAA;
    mem[6]  = 17'h00000;
    mem[63] = 17'h1FFFF;

    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values
    #12;
    check("rst.valid",  32'(if_valid),    32'd0);
    check("rst.instr",  32'(if_instr),    32'd0);
    check("rst.pc",     32'(if_pc),       32'd0);
    check("rst.pc1",    32'(if_pc_plus1), 32'd0);
    check("rst.halted", 32'(halted),      32'd0);
    check("rst.addr",   32'(imem_addr),   32'd0);
    check("rst.ir_en",  32'(ir_enable),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rel.ir_en", 32'(ir_enable), 32'd1);

    // Free-run: one word per cycle from address 0
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("run%0d", k), 1'b1, 6'(k), mem[k]);
      check($sformatf("run%0d.pc1", k), 32'(if_pc_plus1), 32'(k + 1));
      check($sformatf("run%0d.addr", k), 32'(imem_addr), 32'(k + 1));
    end

    // Stall 3 cycles holding if_pc=2
    if_ready = 1'b0;
    #0;
    check("stall.ir_en", 32'(ir_enable), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("stall%0d", k), 1'b1, 6'd2, 17'h06587);
      check($sformatf("stall%0d.addr", k), 32'(imem_addr), 32'd3);
    end
    if_ready = 1'b1;
    #0;
    check("unstall.ir_en", 32'(ir_enable), 32'd1);
    tick();
    check_out("unstall", 1'b1, 6'd3, 17'h0B000);

    // Get if_pc=1 valid, then redirect to 5 with if_ready high
    do_redirect(6'd1);
    tick();
    check_out("at1", 1'b1, 6'd1, 17'h0C217);
    do_redirect(6'd5);
    #0;
    check("post_redir.ir_en", 32'(ir_enable), 32'd1);
    tick();
    check_out("redir5", 1'b1, 6'd5, 17'h0AAAA);

    // Back-to-back redirects: last wins, valid stays low
    redirect_valid = 1'b1;
    redirect_pc    = 6'd10;
    tick();
    check("b2b.valid0", 32'(if_valid), 32'd0);
    redirect_pc = 6'd20;
    tick();
    check("b2b.valid1", 32'(if_valid), 32'd0);
    check("b2b.addr",   32'(imem_addr), 32'd20);
    redirect_valid = 1'b0;
    tick();
    check_out("b2b", 1'b1, 6'd20, 17'h10014);

    // Wrap 63 -> 0
    do_redirect(6'd63);
    tick();
    check_out("wrap63", 1'b1, 6'd63, 17'h1FFFF);
    check("wrap63.pc1",  32'(if_pc_plus1), 32'd0);
    check("wrap63.addr", 32'(imem_addr),   32'd0);
    tick();
    check_out("wrap0", 1'b1, 6'd0, 17'h00001);
    check("wrap0.pc1", 32'(if_pc_plus1), 32'd1);

    // Zero word at address 6
    do_redirect(6'd5);
    tick();
    check_out("z5", 1'b1, 6'd5, 17'h0AAAA);
    tick();
    check_out("z6", 1'b1, 6'd6, 17'h00000);
    check("z6.addr", 32'(imem_addr), 32'd7);
`ifdef FETCH_ZERO_HALT_EN
    check("z6.halted", 32'(halted), 32'd1);
    check("z6.ir_en",  32'(ir_enable), 32'd0);
    tick();
    check("halt.valid",  32'(if_valid),  32'd0);
    check("halt.halted", 32'(halted),    32'd1);
    check("halt.addr",   32'(imem_addr), 32'd7);
    tick();
    check("halt2.valid", 32'(if_valid),  32'd0);
    check("halt2.addr",  32'(imem_addr), 32'd7);
    check("halt2.ir_en", 32'(ir_enable), 32'd0);
    do_redirect(6'd0);
    check("unhalt.halted", 32'(halted), 32'd0);
    tick();
    check_out("resume", 1'b1, 6'd0, 17'h00001);
`else
    check("z6.halted", 32'(halted), 32'd0);
    tick();
    check_out("z7", 1'b1, 6'd7, 17'h10007);
    check("z7.halted", 32'(halted), 32'd0);
`endif

    // Async reset mid-stall, between edges
    if_ready = 1'b0;
    tick();
    check("pre_arst.valid", 32'(if_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(if_valid),  32'd0);
    check("arst.addr",  32'(imem_addr), 32'd0);
    check("arst.pc",    32'(if_pc),     32'd0);
    check("arst.ir_en", 32'(ir_enable), 32'd0);
    #10;
    rst_n    = 1'b1;
    if_ready = 1'b1;
    tick();
    check_out("post_arst", 1'b1, 6'd0, 17'h00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-register stage directly upstream of the decoder. Directly downstream of nothing; it drives instruction memory.
- Drives the 6-bit address into instruction_memory. Instruction memory reads asynchronously.
- Captures the returned 17-bit word into an output register and hands it to decode with a valid/ready handshake.
- Accepts redirects (jump/branch-taken) from execute, which flush the held instruction.

Parameters:
- ADDR_W, 6, PC / instruction-memory address width (64 words).
- INSTR_W, 17, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_W  address to instruction memory; equals pc register.
- imem_instr  in  INSTR_W  combinational read data from instruction memory.
- ir_enable  out  1  high in cycles where IR loads; drives memory IR_enable.
- redirect_valid  in  1  jump/branch-taken request from execute.
- redirect_pc  in  ADDR_W  redirect target.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_ready  in  1  decoder accepts this cycle.
- if_instr  out  INSTR_W  registered instruction.
- if_pc  out  ADDR_W  address the instruction was fetched from.
- if_pc_plus1  out  ADDR_W  if_pc+1 mod 2^ADDR_W, registered.
- halted  out  1  only with FETCH_ZERO_HALT_EN; otherwise tied 0.

Behaviour:
- Reset (async assert, synchronous-safe deassert):
  - pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pc_plus1=0; halted=0.
  - ir_enable=0 while rst_n low.
- load = !redirect_valid && (!if_valid || if_ready). ir_enable = load (combinational).
- On a load edge:
  - if_instr<=imem_instr; if_pc<=pc; if_pc_plus1<=pc+1; pc<=pc+1; if_valid<=1.
  - Fetch latency: address presented in cycle N, instruction visible at output after edge N.
- Stall (if_valid && !if_ready && !redirect_valid): pc, if_instr, if_pc, if_pc_plus1 and if_valid all hold. The output must stay stable while valid and not accepted.
- Redirect (highest priority):
  - pc<=redirect_pc; if_valid<=0; no IR load.
  - if_instr/if_pc keep their old values (don't-care while invalid).
  - If if_ready is high in the same cycle, the handshake on the current word still completes; only subsequent fetches are squashed.
- Next cycle after a redirect: imem_addr=redirect_pc; load occurs normally (if_valid=0 implies load).
- PC arithmetic is modulo 2^ADDR_W: 63+1 -> 0, no flag. if_pc_plus1 wraps identically.
- Throughput: with if_ready held high and no redirects, one instruction per cycle; if_valid stays 1 continuously.
- Back-to-back redirects: each overrides; the last one wins; if_valid stays 0 throughout.
- Reset mid-stall or mid-redirect: immediate return to reset values; the pending instruction is lost.
- States (implicit via if_valid/halted): EMPTY (if_valid=0), FULL (if_valid=1), HALT (optional).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on redirect, or on if_ready with no load (only when halted).
  - FULL -> FULL on accept+load or stall.

Optional Feature:
- Macro FETCH_ZERO_HALT_EN.
- When defined:
  - A loaded word equal to all zeros sets halted<=1 on that same edge. The zero word is still presented with if_valid=1.
  - While halted, load is forced 0 and pc holds. After the zero word is accepted, if_valid goes 0.
  - halted clears only on redirect_valid (pc<=redirect_pc, fetching resumes next cycle) or on reset.
- When undefined: halted is tied 0; zero words are fetched like any other word.

Test Plan:
- Reset then free-run: memory[0..3]=17'h00001,17'h0C217,17'h0658 7,17'h0B000; if_ready=1.
  - Expect if_valid high from the first edge after reset release.
  - Expect if_pc 0,1,2,3 on consecutive cycles, with if_instr matching the memory word.
- Stall: with if_pc=2 valid, hold if_ready=0 for 3 cycles -> if_instr, if_pc=2, imem_addr=3 unchanged. Release -> if_pc=3 on the next edge.
- Redirect: redirect_valid=1, redirect_pc=5, if_ready=1 while if_pc=1.
  - Next edge: if_valid=0, imem_addr=5.
  - Following edge: if_pc=5, if_instr=memory[5].
- Wrap: redirect to 63, free-run -> if_pc 63 then 0; if_pc_plus1 for 63 is 0.
- Async reset mid-stall: assert rst_n=0 between edges -> if_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
- With FETCH_ZERO_HALT_EN: memory[6]=0, free-run from 5.
  - if_pc=6 is presented, then halted=1, if_valid=0, imem_addr stays 7.
  - redirect_pc=0 clears halted; fetch resumes at 0.
